operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage directly upstream of the shifter/ALU stage.
//  - Owns the general-purpose register bank; accepts write-back from later stages.
//  - Reads Rn (into A) then Rm (into B) through one shared read port.
//  - Presents A, B and the 2-bit shift code to the shifter over a valid/ready handshake.
// PARAMETERS
//  DW     16  datapath word width
//  NREGS  8   number of registers; AW = $clog2(NREGS) (3 at default)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   fetch request presented
//  req_ready  out  1   stage can accept a request this cycle
//  rn         in   AW  A-operand register number (sampled on accept)
//  rm         in   AW  B-operand register number (sampled on accept)
//  use_a      in   1   0: no A operand (e.g. MOV); A forced to 0, read skipped
//  shift_in   in   2   shift code; passed through unchanged to shift_out
//  wb_en      in   1   register write enable
//  wb_num     in   AW  write register number
//  wb_data    in   DW  write data
//  out_valid  out  1   a_out/b_out/shift_out valid for the shifter stage
//  out_ready  in   1   shifter stage accepts operands
//  a_out      out  DW  A operand
//  b_out      out  DW  B operand (feeds shifter input)
//  shift_out  out  2   shift code: 00 none, 01 lsl1, 10 lsr1, 11 asr1
// BEHAVIOUR
//  - Reset (sync): FSM->IDLE; out_valid=0; a_out=b_out=0; shift_out=00; all registers=0; wb_en ignored.
//  - Reset mid-operation: in-flight fetch dropped; nothing presented afterwards.
//  - FSM states:
//      IDLE  : accept when req_valid; use_a=1 -> RD_A, use_a=0 -> RD_B.
//      RD_A  : read port=rn_q; A<=data; -> RD_B.
//      RD_B  : read port=rm_q; B<=data; -> HOLD.
//      HOLD  : out_valid=1; out_ready=1 -> IDLE, or -> RD_A/RD_B if a new request is accepted same cycle.
//  - req_ready = (state==IDLE) | (state==HOLD & out_ready).
//  - Request fields (rn, rm, use_a, shift_in) are captured into *_q on accept.
//  - Latency: accept -> out_valid is 3 cycles with use_a=1, 2 cycles with use_a=0.
//  - Peak throughput: one op per 3 cycles.
//  - HOLD stalls on out_ready=0: a_out, b_out, shift_out held stable, out_valid stays 1.
//  - A/B are snapshots: writes after latching never alter a_out/b_out.
//  - Register write: bank[wb_num] <= wb_data on posedge when wb_en, in every state.
//  - Read port is combinational from the bank; read data is sampled at the same edge as any write.
//  - Same-cycle write/read of one register: see CONFIGURATION.
//  - Reads of register 0 return the stored value; no hardwired zero.
//  - No arithmetic; all data paths are exact DW wide, no extension or truncation.
// CONFIGURATION
//  FORWARD_EN defined:
//    - read data = wb_data when wb_en and wb_num == current read address;
//    - the operand latches the new value in the same cycle.
//  FORWARD_EN undefined:
//    - read data = old bank contents;
//    - the new value is visible from the next cycle only.
// STRUCTURE
//  datapath_pkg holds:
//    - word_t logic[15:0], reg_num_t logic[2:0];
//    - shift_t with SH_NONE/SH_LSL/SH_LSR/SH_ASR constants;
//    - fetch_state_t enum {IDLE, RD_A, RD_B, HOLD}.
//  Sub-module reg_bank: NREGS x DW storage, one sync write port, one async read port.
//  operand_fetch holds the FSM, request capture, forwarding mux and operand registers.
// TESTING
//  1. Reset then idle:
//     - a_out=0, b_out=0, out_valid=0, req_ready=1;
//     - read of r5 returns 0x0000.
//  2. Write r1=0x1234, r2=0x00F0; request rn=1, rm=2, use_a=1, shift=01, out_ready=1:
//     - out_valid on 3rd cycle after accept;
//     - a_out=0x1234, b_out=0x00F0, shift_out=01.
//  3. use_a=0, rm=2, shift=11:
//     - out_valid 2 cycles after accept;
//     - a_out=0x0000, b_out=0x00F0, shift_out=11.
//  4. Stall: out_ready=0 for 5 cycles while r2 is rewritten to 0xBEEF:
//     - outputs stay 0x1234/0x00F0 and out_valid=1 throughout;
//     - out_ready=1 -> handshake completes.
//  5. In RD_B with rm=3, write r3=0xA5A5 in the same cycle:
//     - b_out=0xA5A5 with FORWARD_EN;
//     - b_out=old r3 without it.
//  6. Assert reset during RD_A:
//     - next cycle IDLE, out_valid=0, all registers 0;
//     - no stale operand is ever presented.

Source files
------------

// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg
//   Shared types for the operand-fetch / shifter datapath.
//   - word_t, reg_num_t : default-width data word and register number
//   - shift_t + SH_*    : 2-bit shift code handed to the shifter stage
//   - fetch_state_t     : operand-fetch FSM states
// ----------------------------------------------------------------------------
package datapath_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_num_t;

    typedef logic [1:0]  shift_t;
    localparam shift_t SH_NONE = 2'b00;
    localparam shift_t SH_LSL  = 2'b01;
    localparam shift_t SH_LSR  = 2'b10;
    localparam shift_t SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/reg_bank.sv
// ----------------------------------------------------------------------------
// reg_bank
//   NREGS x DW general-purpose register storage.
//   One synchronous write port, one combinational read port. Reads return the
//   stored contents (no bypass here; forwarding lives in the fetch stage).
//   Ports:
//     clk, reset        : clock, synchronous active-high reset (clears bank)
//     wr_en/addr/data   : write port, applied on posedge when wr_en
//     rd_addr, rd_data  : asynchronous read port
// ----------------------------------------------------------------------------
module reg_bank
    import datapath_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] bank_q [NREGS];
    logic [DW-1:0] bank_d [NREGS];

    // NOTE: every always_comb output starts from a full default (here the
    // current contents) so no path leaves it unassigned and no latch appears.
    always_comb begin
        bank_d = bank_q;
        if (wr_en) begin
            bank_d[wr_addr] = wr_data;
        end
    end

    // NOTE: the bank is reset explicitly because register contents after reset
    // are architecturally visible (all zero); writes are ignored during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rd_data = bank_q[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
//   Operand-fetch stage in front of the shifter/ALU. Owns the register bank,
//   takes write-back from later stages, reads Rn then Rm through one shared
//   read port and presents A, B and the shift code over valid/ready.
//   Configuration macro: FORWARD_EN
//     defined   : a same-cycle write to the register being read is forwarded
//                 into the operand latch.
//     undefined : the read sees the old bank contents.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     req_valid/req_ready        : request handshake
//     rn, rm, use_a, shift_in    : request fields, captured on accept
//     wb_en, wb_num, wb_data     : register write-back port (any state)
//     out_valid/out_ready        : operand handshake to the shifter
//     a_out, b_out, shift_out    : operands and shift code
// ----------------------------------------------------------------------------
module operand_fetch
    import datapath_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] rn,
    input  logic [AW-1:0] rm,
    input  logic          use_a,
    input  shift_t        shift_in,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_num,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output shift_t        shift_out
);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] rn_q, rn_d;
    logic [AW-1:0] rm_q, rm_d;
    logic          use_a_q, use_a_d;
    shift_t        shift_q, shift_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] bank_rd_data;
    logic [DW-1:0] rd_word;
    logic          accept;

    // The single read port serves Rn while in RD_A and Rm otherwise.
    assign rd_addr = (state_q == RD_A) ? rn_q : rm_q;

    reg_bank #(
        .DW    (DW),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wb_en),
        .wr_addr (wb_num),
        .wr_data (wb_data),
        .rd_addr (rd_addr),
        .rd_data (bank_rd_data)
    );

`ifdef FORWARD_EN
    // Bypass: the operand latch sees this cycle's write to the same register.
    assign rd_word = (wb_en && (wb_num == rd_addr)) ? wb_data : bank_rd_data;
`else
    assign rd_word = bank_rd_data;
`endif

    assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        use_a_d = use_a_q;
        shift_d = shift_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
                // A new request may be taken in the same cycle HOLD drains.
                if (accept) begin
                    rn_d    = rn;
                    rm_d    = rm;
                    use_a_d = use_a;
                    shift_d = shift_in;
                    state_d = use_a ? RD_A : RD_B;
                end
            end
            RD_A: begin
                a_d     = rd_word;
                state_d = RD_B;
            end
            RD_B: begin
                b_d = rd_word;
                // Ops without an A operand present A as zero.
                if (!use_a_q) begin
                    a_d = '0;
                end
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rn_q    <= '0;
            rm_q    <= '0;
            use_a_q <= 1'b0;
            shift_q <= SH_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            use_a_q <= use_a_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign shift_out = shift_q;

endmodule
